// File: rtl/uart_pkg.sv
// Shared UART framing package: header default, CRC-8 constants and the
// transmitter FSM state encoding. Also imported by uart_mult_byte_rx.
package uart_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
  localparam logic [7:0] CRC8_POLY      = 8'h07;
  localparam logic [7:0] CRC8_INIT      = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_crc8_byte.sv
// Combinational CRC-8 (poly 0x07, non-reflected) advanced by one byte.
// Ports:
//   crc        - current CRC value
//   data       - byte folded into the CRC
//   next_crc_c - CRC after consuming data (combinational)
module uart_crc8_byte
  import uart_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] next_crc_c
);

  logic [7:0] acc;

  // Eight MSB-first shift/XOR steps of the polynomial division.
  always_comb begin
    acc = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (acc[7]) acc = {acc[6:0], 1'b0} ^ CRC8_POLY;
      else        acc = {acc[6:0], 1'b0};
    end
    next_crc_c = acc;
  end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART frame transmitter: HEADER, LEN, payload[0..LEN-1], CRC-8,
// each byte sent 8N1 LSB first.
// Ports:
//   sys_clk, sys_rst - clock, synchronous active-high reset
//   tx_start         - one-cycle frame request (ignored while busy)
//   tx_len           - payload byte count, clamped to MAX_BYTES
//   tx_payload       - payload, byte k at [8k+7:8k]
//   uart_txd         - serial line, idle high
//   tx_busy          - frame in flight
//   tx_done          - one-cycle completion pulse
//   tx_byte_cnt      - index of byte on the line (0 = header)
module uart_mult_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned UART_BPS  = 115200,
  parameter int unsigned MAX_BYTES = 12,
  parameter logic [7:0]  HEADER    = HEADER_DEFAULT
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   tx_start,
  input  logic [3:0]             tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_payload,
  output logic                   uart_txd,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [7:0]             tx_byte_cnt
);

  localparam int unsigned BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam int unsigned PAY_W    = 8 * MAX_BYTES;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [3:0]       LEN_MAX   = 4'(MAX_BYTES);

  tx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic [PAY_W-1:0] payload_q;
  logic [3:0]       len_q;
  logic [7:0]       crc_q;

  logic       accept_c;
  logic       bit_end_c;
  logic       last_byte_c;
  logic       next_is_crc_c;
  logic [3:0] len_clamp_c;
  logic [7:0] crc_idx_c;
  logic [7:0] next_idx_c;
  logic [7:0] next_byte_c;
  logic [7:0] crc_next_c;

  // Byte sequencing: index 0 header, 1 LEN, 2..LEN+1 payload, LEN+2 CRC.
  always_comb begin
    len_clamp_c   = (tx_len > LEN_MAX) ? LEN_MAX : tx_len;
    accept_c      = tx_start && !tx_busy && (state == IDLE);
    bit_end_c     = (baud_cnt == BAUD_LAST);
    crc_idx_c     = {4'd0, len_q} + 8'd2;
    next_idx_c    = tx_byte_cnt + 8'd1;
    last_byte_c   = (tx_byte_cnt == crc_idx_c);
    next_is_crc_c = (next_idx_c == crc_idx_c);
    if (next_idx_c == 8'd1)  next_byte_c = {4'd0, len_q};
    else if (next_is_crc_c)  next_byte_c = crc_q;
    else                     next_byte_c = payload_q[7:0];
  end

  // CRC runs over the byte being loaded, so it is final one byte ahead of use.
  uart_crc8_byte u_crc (
    .crc        (crc_q),
    .data       (next_byte_c),
    .next_crc_c (crc_next_c)
  );

  // Frame FSM with registered line and status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      payload_q   <= '0;
      len_q       <= '0;
      crc_q       <= CRC8_INIT;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_byte_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            state       <= START;
            uart_txd    <= 1'b0;
            tx_busy     <= 1'b1;
            tx_byte_cnt <= '0;
            shift_q     <= HEADER;
            payload_q   <= tx_payload;
            len_q       <= len_clamp_c;
            crc_q       <= CRC8_INIT;
            baud_cnt    <= '0;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= shift_q[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shift_q[1];
              shift_q  <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            baud_cnt <= '0;
            if (last_byte_c) begin
              state   <= DONE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              state       <= START;
              uart_txd    <= 1'b0;
              tx_byte_cnt <= next_idx_c;
              shift_q     <= next_byte_c;
              if (!next_is_crc_c) crc_q <= crc_next_c;
              // Payload is consumed from the bottom byte upwards.
              if (!next_is_crc_c && (next_idx_c >= 8'd2))
                payload_q <= payload_q >> 8;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
